pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the pipeline hazard detector.
- Decodes the RV32I instruction in ID and tracks in-flight destination registers in an internal scoreboard of DEPTH stages.
- Produces a combinational load-use stall and registered per-source forwarding selects; load latency is configurable.
- Sits between the ID/EX pipeline register and the EX operand muxes, which use fwd_sel to pick regfile or the stage-j pipeline register result.

Parameters:
DEPTH, 3, in-flight stages tracked after ID (1 = EX/MEM reg, 2 = MEM/WB reg, 3 = WB-out); valid range 2..6
LOAD_LAT, 1, extra cycles after EX before load data exists; valid range 1..DEPTH-1
REG_AW, 5, register address width (4 for RV32E; rd/rs fields truncated to REG_AW LSBs)
SEL_W, $clog2(DEPTH+1), width of forward-select outputs

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-low reset
id_inst  in  32  instruction currently in ID
id_valid  in  1  ID holds a real instruction
hold  in  1  global freeze (memory wait); freezes all state
flush  in  1  kill ID instruction this cycle (branch/jump taken)
stall  out  1  combinational: hold IF/ID, insert bubble into EX
issue  out  1  combinational: id_valid & ~stall & ~flush & ~hold
fwd_sel_rs1  out  SEL_W  registered operand-1 source for the instruction now in EX; 0 = regfile, j = stage-j result
fwd_sel_rs2  out  SEL_W  registered operand-2 source, same encoding
stall_count  out  32  saturating count of cycles with stall & ~hold & ~flush

Behaviour:
- Decode (combinational), by opcode:
  - uses_rs1 for all opcodes except LUI, AUIPC, JAL.
  - uses_rs2 for R-type (0110011), STORE (0100011), BRANCH (1100011) only.
  - writes_rd for R-type, I-ALU (0010011), LOAD (0000011), LUI, AUIPC, JAL, JALR, and only if rd != 0.
  - is_load for opcode 0000011.
  - Unknown opcodes: no uses, no write.
- Scoreboard entry k (1..DEPTH) = {valid, rd, is_load}. Entry k holds the producer that will sit at source index k when the current ID instruction reaches EX.
- Advance rule: if ~hold, entry[1] <= issue ? {writes_rd, rd, is_load} : bubble, and entry[k+1] <= entry[k]. If hold, all entries and fwd_sel registers keep their values.
- Match for source s: uses_s & rs_s != 0 & entry[k].valid & entry[k].rd == rs_s. The youngest match (smallest k) wins; older matches are ignored.
- Load-use: if the winning match is a load and k < LOAD_LAT+1, then stall = id_valid & ~flush. Checked for both sources and ORed.
- Selects: fwd_sel_s <= issue ? (winning k, or 0 if no match) : 0, updated only when ~hold.
- A bubble (stall, flush, or ~id_valid) always produces selects of 0.
- Rewind after stall: the load moves to entry k+1 next cycle and the stall reevaluates. With LOAD_LAT=1 this gives exactly one bubble; with LOAD_LAT=2 and the load at k=1, two bubbles.
- Priority:
  - flush forces stall=0 and issue=0.
  - hold forces issue=0; stall is still computed, but stall_count does not increment.
- Reset (rst==0 at posedge): all entries invalid; fwd_sel_rs1 = fwd_sel_rs2 = 0; stall_count = 0. stall and issue depend only on inputs plus the cleared scoreboard, so stall=0 during reset.
- Reset mid-stall: the scoreboard clears, so the next cycle issues with no hazard.
- stall_count saturates at 32'hFFFF_FFFF.
- Producers older than DEPTH are assumed written to the regfile, which has write-before-read; select 0.

Decomposition:
- Package hazard_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM);
  - the scoreboard entry struct {valid, rd, is_load};
  - the fwd_sel encoding constant FWD_REGFILE = 0.
- Sub-module hazard_decode: combinational decode of id_inst to {rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, is_load}, parametrised by REG_AW.

Test Plan:
- Back-to-back ALU: issue add x5,x1,x2 then add x6,x5,x5 -> stall=0 both cycles; fwd_sel_rs1 = fwd_sel_rs2 = 1 while the second add is in EX.
- Load-use, LOAD_LAT=1: lw x7,0(x1) then add x8,x7,x3 -> exactly 1 stall cycle, stall_count=1; then fwd_sel_rs1=2, fwd_sel_rs2=0. Repeat with LOAD_LAT=2 -> 2 stall cycles, then fwd_sel_rs1=3.
- Youngest-wins: addi x5,x0,1; addi x5,x0,2; add x9,x5,x0 -> fwd_sel_rs1=1 (not 2); rs2=x0 gives fwd_sel_rs2=0.
- No-source / x0: lw x0,0(x1) then add x2,x0,x0, and lui x3 after lw x3 -> stall=0, selects 0.
- hold and flush: assert hold for 3 cycles during a load-use stall -> entries and fwd_sel frozen, stall_count unchanged. flush with a pending hazard -> stall=0, issue=0, bubble in entry 1.
- Reset mid-stall: drop rst during a load-use stall -> next cycle stall=0, fwd_sel=0, stall_count=0. Also compare DEPTH=4 against DEPTH=3: a producer at k=4 gives select 4 vs 0.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared definitions for the pipeline hazard unit: RV32I
//               opcode values, the scoreboard entry layout and the
//               forward-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Widest register address the scoreboard has to hold (RV32I).
    // Narrower configurations store their address zero-extended.
    localparam int RD_W = 5;

    // Forward-select value meaning "take the operand from the regfile".
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } sb_entry_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_decode.sv
`default_nettype none
// ============================================================================
// Module      : hazard_decode
// Description : Combinational decode of the ID instruction into the register
//               fields and the use/write/load flags the hazard logic needs.
//               Register fields are truncated to REG_AW LSBs.
// Ports       : i_inst      - instruction in ID
//               o_rs1/o_rs2 - source register addresses
//               o_rd        - destination register address
//               o_uses_rs1  - instruction reads rs1
//               o_uses_rs2  - instruction reads rs2
//               o_writes_rd - instruction writes a non-zero rd
//               o_is_load   - instruction is a load
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_decode
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       i_inst,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_uses_rs1,
    output logic              o_uses_rs2,
    output logic              o_writes_rd,
    output logic              o_is_load
);

    logic [6:0] w_opcode;
    logic       w_has_rd;
    // funct3/funct7/immediate bits are irrelevant to hazard detection
    logic       w_unused;

    assign w_opcode = i_inst[6:0];
    assign o_rd     = i_inst[7 +: REG_AW];
    assign o_rs1    = i_inst[15 +: REG_AW];
    assign o_rs2    = i_inst[20 +: REG_AW];
    assign w_unused = ^i_inst;

    always_comb begin
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        w_has_rd   = 1'b0;
        o_is_load  = 1'b0;
        case (w_opcode)
            OP_R:      begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; w_has_rd = 1'b1; end
            OP_I:      begin o_uses_rs1 = 1'b1; w_has_rd = 1'b1; end
            OP_LOAD:   begin o_uses_rs1 = 1'b1; w_has_rd = 1'b1; o_is_load = 1'b1; end
            OP_STORE:  begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
            OP_BRANCH: begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
            OP_LUI:    w_has_rd = 1'b1;
            OP_AUIPC:  w_has_rd = 1'b1;
            OP_JAL:    w_has_rd = 1'b1;
            OP_JALR:   begin o_uses_rs1 = 1'b1; w_has_rd = 1'b1; end
            OP_SYSTEM: o_uses_rs1 = 1'b1;
            default:   ;
        endcase
    end

    // x0 is hardwired zero, so writing it never creates a dependency
    assign o_writes_rd = w_has_rd && (o_rd != '0);

endmodule : hazard_decode
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit
// Description : Load-use stall and operand forwarding control for an RV32I
//               pipeline. A DEPTH-entry scoreboard records the destination of
//               every instruction issued from ID; entry k is the producer that
//               sits at pipeline source index k once the current ID
//               instruction reaches EX.
// Ports       : clk          - clock, all state on posedge
//               rst          - synchronous active-low reset
//               id_inst      - instruction currently in ID
//               id_valid     - ID holds a real instruction
//               hold         - global freeze, all state keeps its value
//               flush        - kill the ID instruction this cycle
//               stall        - comb: hold IF/ID, bubble into EX
//               issue        - comb: ID instruction advances to EX
//               fwd_sel_rs1  - reg: operand-1 source for EX (0 = regfile)
//               fwd_sel_rs2  - reg: operand-2 source for EX (0 = regfile)
//               stall_count  - saturating count of counted stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [SEL_W-1:0] fwd_sel_rs1,
    output logic [SEL_W-1:0] fwd_sel_rs2,
    output logic [31:0]      stall_count
);

    logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
    logic              w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;

    sb_entry_t         r_sb [1:DEPTH];
    logic [DEPTH:1]    w_hit_rs1, w_hit_rs2;
    logic [SEL_W-1:0]  w_sel_rs1, w_sel_rs2;
    logic              w_lu_rs1, w_lu_rs2;
    sb_entry_t         w_new_entry;

    logic [SEL_W-1:0]  r_fwd_sel_rs1, r_fwd_sel_rs2;
    logic [31:0]       r_stall_count;

    hazard_decode #(
        .REG_AW (REG_AW)
    ) u_decode (
        .i_inst      (id_inst),
        .o_rs1       (w_rs1),
        .o_rs2       (w_rs2),
        .o_rd        (w_rd),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_writes_rd (w_writes_rd),
        .o_is_load   (w_is_load)
    );

    // Per-entry address compare for both sources
    for (genvar k = 1; k <= DEPTH; k++) begin : g_match
        assign w_hit_rs1[k] = w_uses_rs1 && (w_rs1 != '0) && r_sb[k].valid &&
                              (r_sb[k].rd[REG_AW-1:0] == w_rs1);
        assign w_hit_rs2[k] = w_uses_rs2 && (w_rs2 != '0) && r_sb[k].valid &&
                              (r_sb[k].rd[REG_AW-1:0] == w_rs2);
    end

    // Scan oldest to youngest so the youngest hit is the last one written.
    // A load hit within LOAD_LAT stages has no data yet and must stall.
    always_comb begin
        w_sel_rs1 = SEL_W'(FWD_REGFILE);
        w_sel_rs2 = SEL_W'(FWD_REGFILE);
        w_lu_rs1  = 1'b0;
        w_lu_rs2  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_hit_rs1[k]) begin
                w_sel_rs1 = SEL_W'(k);
                w_lu_rs1  = r_sb[k].is_load && (k <= LOAD_LAT);
            end
            if (w_hit_rs2[k]) begin
                w_sel_rs2 = SEL_W'(k);
                w_lu_rs2  = r_sb[k].is_load && (k <= LOAD_LAT);
            end
        end
    end

    assign stall = id_valid && !flush && (w_lu_rs1 || w_lu_rs2);
    assign issue = id_valid && !stall && !flush && !hold;

    always_comb begin
        w_new_entry = '0;
        if (issue) begin
            w_new_entry.valid   = w_writes_rd;
            w_new_entry.rd      = RD_W'(w_rd);
            w_new_entry.is_load = w_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_sb[k] <= '0;
            end
            r_fwd_sel_rs1 <= SEL_W'(FWD_REGFILE);
            r_fwd_sel_rs2 <= SEL_W'(FWD_REGFILE);
            r_stall_count <= '0;
        end else if (!hold) begin
            r_sb[1] <= w_new_entry;
            for (int k = 2; k <= DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_fwd_sel_rs1 <= issue ? w_sel_rs1 : SEL_W'(FWD_REGFILE);
            r_fwd_sel_rs2 <= issue ? w_sel_rs2 : SEL_W'(FWD_REGFILE);
            // stall is already gated by flush
            if (stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fwd_sel_rs1 = r_fwd_sel_rs1;
    assign fwd_sel_rs2 = r_fwd_sel_rs2;
    assign stall_count = r_stall_count;

endmodule : pipeline_hazard_unit
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_unit
// Description : Directed self-checking bench. Three configurations share one
//               input stream: DEPTH=3/LOAD_LAT=1, DEPTH=3/LOAD_LAT=2 and
//               DEPTH=4/LOAD_LAT=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    logic        clk;
    logic        rst;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        hold;
    logic        flush;

    logic        a_stall, a_issue;
    logic [1:0]  a_fwd1, a_fwd2;
    logic [31:0] a_cnt;

    logic        b_stall, b_issue;
    logic [1:0]  b_fwd1, b_fwd2;
    logic [31:0] b_cnt;

    logic        c_stall, c_issue;
    logic [2:0]  c_fwd1, c_fwd2;
    logic [31:0] c_cnt;

    int n_pass  = 0;
    int n_check = 0;

    pipeline_hazard_unit #(.DEPTH(3), .LOAD_LAT(1)) u_d3 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
        .hold(hold), .flush(flush), .stall(a_stall), .issue(a_issue),
        .fwd_sel_rs1(a_fwd1), .fwd_sel_rs2(a_fwd2), .stall_count(a_cnt)
    );

    pipeline_hazard_unit #(.DEPTH(3), .LOAD_LAT(2)) u_ll2 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
        .hold(hold), .flush(flush), .stall(b_stall), .issue(b_issue),
        .fwd_sel_rs1(b_fwd1), .fwd_sel_rs2(b_fwd2), .stall_count(b_cnt)
    );

    pipeline_hazard_unit #(.DEPTH(4), .LOAD_LAT(1)) u_d4 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
        .hold(hold), .flush(flush), .stall(c_stall), .issue(c_issue),
        .fwd_sel_rs1(c_fwd1), .fwd_sel_rs2(c_fwd2), .stall_count(c_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] add_i(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] lw_i(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] addi_i(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] lui_i(input int rd);
        return {20'h00001, 5'(rd), 7'b0110111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        id_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        id_inst  = '0;
        id_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;

        // ---- reset state, with a would-be consumer sitting in ID ----
        id_valid = 1'b1;
        id_inst  = add_i(8, 7, 3);
        tick();
        tick();
        chk("rst_stall", a_stall, 0);
        chk("rst_fwd1",  a_fwd1, 0);
        chk("rst_fwd2",  a_fwd2, 0);
        chk("rst_cnt",   a_cnt, 0);

        // ---- back-to-back ALU forwarding ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = add_i(5, 1, 2);
        #1;
        chk("b2b_stall0", a_stall, 0);
        chk("b2b_issue0", a_issue, 1);
        tick();
        id_inst = add_i(6, 5, 5);
        #1;
        chk("b2b_stall1", a_stall, 0);
        tick();
        chk("b2b_fwd1", a_fwd1, 1);
        chk("b2b_fwd2", a_fwd2, 1);
        id_valid = 1'b0;

        // ---- load-use: LOAD_LAT=1 (u_d3) and LOAD_LAT=2 (u_ll2) ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = lw_i(7, 1);
        #1;
        chk("lu_lw_stall", a_stall, 0);
        tick();
        id_inst = add_i(8, 7, 3);
        #1;
        chk("lu1_stall_a", a_stall, 1);
        chk("lu1_issue_a", a_issue, 0);
        chk("lu2_stall_a", b_stall, 1);
        tick();
        chk("lu1_stall_b", a_stall, 0);
        chk("lu1_issue_b", a_issue, 1);
        chk("lu1_cnt",     a_cnt, 1);
        chk("lu2_stall_b", b_stall, 1);
        tick();
        chk("lu1_fwd1",    a_fwd1, 2);
        chk("lu1_fwd2",    a_fwd2, 0);
        chk("lu1_cnt_end", a_cnt, 1);
        chk("lu2_stall_c", b_stall, 0);
        chk("lu2_issue_c", b_issue, 1);
        chk("lu2_cnt",     b_cnt, 2);
        tick();
        chk("lu2_fwd1", b_fwd1, 3);
        chk("lu2_fwd2", b_fwd2, 0);
        id_valid = 1'b0;

        // ---- youngest producer wins ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = addi_i(5, 0, 1);
        tick();
        id_inst = addi_i(5, 0, 2);
        tick();
        id_inst = add_i(9, 5, 0);
        #1;
        chk("yw_stall", a_stall, 0);
        tick();
        chk("yw_fwd1", a_fwd1, 1);
        chk("yw_fwd2", a_fwd2, 0);
        id_valid = 1'b0;

        // ---- x0 destination and no-source consumer ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = lw_i(0, 1);
        tick();
        id_inst = add_i(2, 0, 0);
        #1;
        chk("x0_stall", a_stall, 0);
        tick();
        chk("x0_fwd1", a_fwd1, 0);
        chk("x0_fwd2", a_fwd2, 0);
        id_inst = lw_i(3, 1);
        tick();
        id_inst = lui_i(3);
        #1;
        chk("lui_stall", a_stall, 0);
        chk("lui_issue", a_issue, 1);
        tick();
        chk("lui_fwd1", a_fwd1, 0);
        id_valid = 1'b0;

        // ---- hold during a load-use stall ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = add_i(1, 2, 3);
        tick();
        id_inst = lw_i(7, 1);
        tick();
        chk("hd_pre_fwd1", a_fwd1, 1);
        id_inst = add_i(8, 7, 3);
        hold    = 1'b1;
        #1;
        chk("hd_stall", a_stall, 1);
        chk("hd_issue", a_issue, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hd_frz_fwd1",  a_fwd1, 1);
            chk("hd_frz_cnt",   a_cnt, 0);
            chk("hd_frz_stall", a_stall, 1);
        end
        hold = 1'b0;
        #1;
        chk("hd_rel_stall", a_stall, 1);
        tick();
        chk("hd_cnt",    a_cnt, 1);
        chk("hd_bub",    a_fwd1, 0);
        chk("hd_issue2", a_issue, 1);
        tick();
        chk("hd_fwd1", a_fwd1, 2);
        chk("hd_fwd2", a_fwd2, 0);
        id_valid = 1'b0;

        // ---- flush with a pending load-use hazard ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = lw_i(7, 1);
        tick();
        id_inst = add_i(8, 7, 3);
        flush   = 1'b1;
        #1;
        chk("fl_stall", a_stall, 0);
        chk("fl_issue", a_issue, 0);
        tick();
        chk("fl_cnt",  a_cnt, 0);
        chk("fl_fwd1", a_fwd1, 0);
        flush = 1'b0;
        #1;
        chk("fl_after_stall", a_stall, 0);
        chk("fl_after_issue", a_issue, 1);
        tick();
        chk("fl_after_fwd1", a_fwd1, 2);
        id_valid = 1'b0;

        // ---- reset in the middle of a stall ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = lw_i(7, 1);
        tick();
        id_inst = add_i(8, 7, 3);
        #1;
        chk("rm_stall_pre", a_stall, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rm_stall", a_stall, 0);
        chk("rm_issue", a_issue, 1);
        chk("rm_cnt",   a_cnt, 0);
        chk("rm_fwd1",  a_fwd1, 0);
        tick();
        chk("rm_fwd1_next", a_fwd1, 0);
        id_valid = 1'b0;

        // ---- producer three stages back: tracked by both depths ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = add_i(5, 1, 2);
        tick();
        id_valid = 1'b0;
        tick();
        tick();
        id_valid = 1'b1;
        id_inst  = add_i(6, 5, 0);
        tick();
        chk("k3_d3_fwd1", a_fwd1, 3);
        chk("k3_d4_fwd1", c_fwd1, 3);

        // ---- producer four stages back: only DEPTH=4 still tracks it ----
        do_reset();
        id_valid = 1'b1;
        id_inst  = add_i(5, 1, 2);
        tick();
        id_valid = 1'b0;
        tick();
        tick();
        tick();
        id_valid = 1'b1;
        id_inst  = add_i(6, 5, 0);
        tick();
        chk("k4_d4_fwd1", c_fwd1, 4);
        chk("k4_d3_fwd1", a_fwd1, 0);
        chk("k4_d4_fwd2", c_fwd2, 0);
        id_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule : tb_pipeline_hazard_unit
`default_nettype wire
